// File: rtl/contador_ocupacao.sv
// ----------------------------------------------------------------------------
// contador_ocupacao
// Passenger occupancy counter for a vehicle door. Two bouncing photo-sensors
// (entry and exit) are synchronized, debounced and turned into single-cycle
// events. Events are applied to a saturating 4-bit count only while the door
// is open. A 2-bit occupancy level code is derived from the count.
//
// Ports
//   clk               in   sole clock, rising edge
//   reset_n           in   synchronous active-low reset
//   sensor_entrada    in   raw asynchronous entry sensor, one pulse per entry
//   sensor_saida      in   raw asynchronous exit sensor, one pulse per exit
//   porta_aberta      in   door open status, synchronous to clk (1 = open)
//   ocupacao          out  [3:0] registered passenger count
//   capacidade_atual  out  [1:0] registered occupancy level code
//   evento_rejeitado  out  one-cycle pulse when an accepted event is discarded
// ----------------------------------------------------------------------------

// ----------------------------------------------------------------------------
// contador_ocupacao_debounce
// 2-flop synchronizer followed by a four-state debounce FSM. A level is
// accepted after DEBOUNCE_CICLOS consecutive stable synchronized samples.
// Only the accepted rising level produces an event pulse.
//
// Ports
//   clk            in   clock
//   reset_n        in   synchronous active-low reset
//   i_sensor       in   raw asynchronous sensor level
//   o_pulso        out  registered one-cycle pulse on accepted rising level
// ----------------------------------------------------------------------------
module contador_ocupacao_debounce #(
   parameter int unsigned DEBOUNCE_CICLOS = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic i_sensor,
   output logic o_pulso
);

   localparam int unsigned CW = 4;
   localparam logic [CW-1:0] CONT_ALVO = CW'(DEBOUNCE_CICLOS);

   typedef enum logic [1:0] {
      ESTAVEL_BAIXO  = 2'd0,
      CONFIRMA_ALTO  = 2'd1,
      ESTAVEL_ALTO   = 2'd2,
      CONFIRMA_BAIXO = 2'd3
   } estado_t;

   logic          r_sinc1;
   logic          r_sinc2;
   estado_t       r_estado;
   estado_t       w_prox_estado;
   logic [CW-1:0] r_cont;
   logic [CW-1:0] w_prox_cont;
   logic          r_pulso;
   logic          w_pulso;
   logic          w_sinc;

   assign w_sinc  = r_sinc2;
   assign o_pulso = r_pulso;

   // Metastability synchronizer for the asynchronous sensor
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_sinc1 <= 1'b0;
         r_sinc2 <= 1'b0;
      end else begin
         r_sinc1 <= i_sensor;
         r_sinc2 <= r_sinc1;
      end
   end

   // Debounce state, counter and event pulse registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_estado <= ESTAVEL_BAIXO;
         r_cont   <= '0;
         r_pulso  <= 1'b0;
      end else begin
         r_estado <= w_prox_estado;
         r_cont   <= w_prox_cont;
         r_pulso  <= w_pulso;
      end
   end

   // Next-state logic. The counter holds the number of consecutive stable
   // samples already seen; once it equals the target the new level is taken.
   always_comb begin
      w_prox_estado = r_estado;
      w_prox_cont   = r_cont;
      w_pulso       = 1'b0;
      case (r_estado)
         ESTAVEL_BAIXO: begin
            if (w_sinc) begin
               w_prox_estado = CONFIRMA_ALTO;
               w_prox_cont   = CW'(1);
            end
         end
         CONFIRMA_ALTO: begin
            if (r_cont == CONT_ALVO) begin
               w_prox_estado = ESTAVEL_ALTO;
               w_prox_cont   = '0;
               w_pulso       = 1'b1;
            end else if (w_sinc) begin
               w_prox_cont   = r_cont + CW'(1);
            end else begin
               w_prox_estado = ESTAVEL_BAIXO;
               w_prox_cont   = '0;
            end
         end
         ESTAVEL_ALTO: begin
            if (!w_sinc) begin
               w_prox_estado = CONFIRMA_BAIXO;
               w_prox_cont   = CW'(1);
            end
         end
         CONFIRMA_BAIXO: begin
            if (r_cont == CONT_ALVO) begin
               w_prox_estado = ESTAVEL_BAIXO;
               w_prox_cont   = '0;
            end else if (!w_sinc) begin
               w_prox_cont   = r_cont + CW'(1);
            end else begin
               w_prox_estado = ESTAVEL_ALTO;
               w_prox_cont   = '0;
            end
         end
         default: begin
            w_prox_estado = ESTAVEL_BAIXO;
            w_prox_cont   = '0;
         end
      endcase
   end

endmodule

module contador_ocupacao #(
   parameter int unsigned DEBOUNCE_CICLOS = 4,
   parameter int unsigned CAP_MAX         = 8
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       sensor_entrada,
   input  logic       sensor_saida,
   input  logic       porta_aberta,
   output logic [3:0] ocupacao,
   output logic [1:0] capacidade_atual,
   output logic       evento_rejeitado
);

   localparam int unsigned LW = 4;
   localparam int unsigned NW = 2;
   localparam logic [LW-1:0] OCUP_CHEIA  = {LW{1'b1}};
   localparam logic [LW-1:0] LIMITE_META = LW'(CAP_MAX / 2);
   localparam logic [LW-1:0] LIMITE_CAP  = LW'(CAP_MAX);

   logic          w_evt_ent;
   logic          w_evt_sai;
   logic [LW-1:0] r_ocupacao;
   logic [LW-1:0] w_ocup_prox;
   logic [NW-1:0] r_capacidade;
   logic [NW-1:0] w_cap_prox;
   logic          r_rejeitado;
   logic          w_rejeitado;

   assign ocupacao         = r_ocupacao;
   assign capacidade_atual = r_capacidade;
   assign evento_rejeitado = r_rejeitado;

   // Entry sensor conditioning
   contador_ocupacao_debounce #(
      .DEBOUNCE_CICLOS (DEBOUNCE_CICLOS)
   ) u_deb_entrada (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_sensor (sensor_entrada),
      .o_pulso  (w_evt_ent)
   );

   // Exit sensor conditioning
   contador_ocupacao_debounce #(
      .DEBOUNCE_CICLOS (DEBOUNCE_CICLOS)
   ) u_deb_saida (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_sensor (sensor_saida),
      .o_pulso  (w_evt_sai)
   );

   // Saturating count update; door closed discards any event, and
   // simultaneous entry/exit with the door open cancel each other.
   always_comb begin
      w_ocup_prox = r_ocupacao;
      w_rejeitado = 1'b0;
      if (w_evt_ent || w_evt_sai) begin
         if (!porta_aberta) begin
            w_rejeitado = 1'b1;
         end else if (w_evt_ent && w_evt_sai) begin
            w_ocup_prox = r_ocupacao;
         end else if (w_evt_ent) begin
            if (r_ocupacao == OCUP_CHEIA) begin
               w_rejeitado = 1'b1;
            end else begin
               w_ocup_prox = r_ocupacao + LW'(1);
            end
         end else begin
            if (r_ocupacao == '0) begin
               w_rejeitado = 1'b1;
            end else begin
               w_ocup_prox = r_ocupacao - LW'(1);
            end
         end
      end
   end

   // Level code from the next count so it moves on the same edge as the count
   always_comb begin
      w_cap_prox = 2'b00;
      if (w_ocup_prox == '0) begin
         w_cap_prox = 2'b00;
      end else if (w_ocup_prox < LIMITE_META) begin
         w_cap_prox = 2'b01;
      end else if (w_ocup_prox < LIMITE_CAP) begin
         w_cap_prox = 2'b10;
      end else begin
         w_cap_prox = 2'b11;
      end
   end

   // Output registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_ocupacao   <= '0;
         r_capacidade <= 2'b00;
         r_rejeitado  <= 1'b0;
      end else begin
         r_ocupacao   <= w_ocup_prox;
         r_capacidade <= w_cap_prox;
         r_rejeitado  <= w_rejeitado;
      end
   end

endmodule
